// File: rtl/multiword_add_sequencer_pkg.sv
// Shared definitions for the nibble-serial wide adder/subtractor.
package multiword_add_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int ADDER_W = 4;

endpackage

// File: rtl/multiword_add_sequencer_adder.sv
// Shared 4-bit ripple datapath reused once per slice by the sequencer.
module propagate_adder
    import multiword_add_sequencer_pkg::*;
(
    input  logic [ADDER_W-1:0] a,
    input  logic [ADDER_W-1:0] b,
    input  logic               cin,
    output logic [ADDER_W-1:0] sum,
    output logic               carry
);

    assign {carry, sum} = {1'b0, a} + {1'b0, b} + {{ADDER_W{1'b0}}, cin};

endmodule

// File: rtl/multiword_add_sequencer.sv
// Adds or subtracts two W-bit operands one nibble per cycle, LSB first,
// chaining the carry through a register between slices.
module multiword_add_sequencer
    import multiword_add_sequencer_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES,
    localparam int IDXW    = $clog2(NIBBLES)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         ovf
);

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic              carry_q, carry_d;
    logic [W-1:0]      result_q, result_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [ADDER_W-1:0] slice_a;
    logic [ADDER_W-1:0] slice_b;
    logic [ADDER_W-1:0] slice_sum;
    logic               slice_carry;
    logic               last_slice;

    assign slice_a    = a_q[ADDER_W*idx_q +: ADDER_W];
    assign slice_b    = b_q[ADDER_W*idx_q +: ADDER_W];
    assign last_slice = (idx_q == IDXW'(NIBBLES - 1));

    propagate_adder u_adder (
        .a     (slice_a),
        .b     (slice_b),
        .cin   (carry_q),
        .sum   (slice_sum),
        .carry (slice_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1, so cin is forced high.
                    a_d      = op_a;
                    b_d      = sub ? ~op_b : op_b;
                    carry_d  = sub | cin;
                    idx_d    = '0;
                    result_d = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                result_d[ADDER_W*idx_q +: ADDER_W] = slice_sum;
                carry_d = slice_carry;
                if (last_slice) begin
                    cout_d  = slice_carry;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) &&
                              (slice_sum[ADDER_W-1] != a_q[W-1]);
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench: vector table, random model vectors, timing corners.
module tb_multiword_add_sequencer;

    typedef struct {
        logic        sub;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] res;
        logic        co;
        logic        ov;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sub;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cout;
    logic        ovf;

    int checks;
    int failures;
    int done_seen;
    vec_t sb[$];
    vec_t mon_e;
    vec_t tbl[11];

    multiword_add_sequencer #(.NIBBLES(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .op_a   (op_a),
        .op_b   (op_b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pops the oldest pushed expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_seen++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL spurious_done result=%h", result);
            end else begin
                mon_e = sb.pop_front();
                if (result !== mon_e.res || cout !== mon_e.co ||
                    ovf !== mon_e.ov) begin
                    failures++;
                    $display("FAIL op a=%h b=%h sub=%b actual=%h/%b/%b required=%h/%b/%b",
                             mon_e.a, mon_e.b, mon_e.sub, result, cout, ovf,
                             mon_e.res, mon_e.co, mon_e.ov);
                end
            end
        end
    end

    function automatic vec_t model(input logic s, input logic [15:0] a,
                                   input logic [15:0] b, input logic c);
        vec_t v;
        logic [15:0] bb;
        logic [16:0] t;
        bb = s ? ~b : b;
        t  = {1'b0, a} + {1'b0, bb} + {16'd0, (s ? 1'b1 : c)};
        v.sub = s; v.a = a; v.b = b; v.cin = c;
        v.res = t[15:0];
        v.co  = t[16];
        v.ov  = (a[15] == bb[15]) && (t[15] != a[15]);
        return v;
    endfunction

    // Called at a negedge; returns negedges from accept edge to done.
    task automatic do_op(input vec_t v, output int lat);
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1; sub = v.sub; op_a = v.a; op_b = v.b; cin = v.cin;
        sb.push_back(v);
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a = 16'($urandom); op_b = 16'($urandom);
        sub = 1'($urandom); cin = 1'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 50);
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout a=%h b=%h", v.a, v.b);
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int t0;
        int t1;
        int t2;
        int ds;
        vec_t v;
        checks = 0; failures = 0; done_seen = 0;
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0;
        op_a = '0; op_b = '0;

        tbl[0]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        // First op by hand: latency, done width and busy length.
        start = 1'b1; sub = 1'b0; op_a = 16'h0000; op_b = 16'h0000; cin = 1'b0;
        sb.push_back(tbl[0]);
        @(posedge clk);
        #1;
        start = 1'b0;
        bcnt = 0;
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done && lat == 0) lat = i;
        end
        check("first_latency", 32'(lat), 32'd5);
        check("busy_cycles", 32'(bcnt), 32'd5);
        check("done_one_cycle", 32'(done), 32'd0);

        for (int i = 1; i < 11; i++) begin
            do_op(tbl[i], lat);
            check("latency", 32'(lat), 32'd5);
        end

        for (int i = 0; i < 16; i++) begin
            v = model(1'($urandom), 16'($urandom), 16'($urandom),
                      1'($urandom));
            do_op(v, lat);
        end

        // Perturb inputs and pulse start while RUN is in flight.
        @(negedge clk);
        ds = done_seen;
        start = 1'b1; sub = 1'b0; op_a = 16'h1234; op_b = 16'h4321; cin = 1'b1;
        sb.push_back(tbl[2]);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            start = (i == 2 || i == 3);
            op_a = 16'($urandom); op_b = 16'($urandom);
            sub = 1'($urandom); cin = 1'($urandom);
            if (i >= 4) start = 1'b0;
        end
        check("perturb_done_count", 32'(done_seen - ds), 32'd1);

        // Start held high: one accept per IDLE visit.
        start = 1'b1; sub = 1'b0; op_a = 16'hFFFF; op_b = 16'h0001; cin = 1'b0;
        repeat (3) sb.push_back(tbl[3]);
        t0 = 0; t1 = 0; t2 = 0;
        ds = 0;
        for (int i = 1; i <= 40 && ds < 3; i++) begin
            @(negedge clk);
            if (done) begin
                ds++;
                if (ds == 1) t0 = i;
                if (ds == 2) t1 = i;
                if (ds == 3) begin
                    t2 = i;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("held_dones", 32'(ds), 32'd3);
        check("spacing_1", 32'(t1 - t0), 32'd6);
        check("spacing_2", 32'(t2 - t1), 32'd6);

        // Reset at idx=2 of a run.
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; sub = 1'b0; op_a = 16'h1234; op_b = 16'h1111; cin = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        v = '{1'b0, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
        do_op(v, lat);
        check("post_rst_latency", 32'(lat), 32'd5);

        repeat (8) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
